// File: rtl/countdown_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | countdown_timer                                                         |
// | HH:MM:SS countdown with load/start/pause control and expiry pulse.      |
// | Optional macro AUTO_RELOAD_EN: reload last accepted load on expiry.     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module countdown_timer #(
    parameter int HH_MAX = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic [5:0] load_hh,
    input  logic [5:0] load_mm,
    input  logic [5:0] load_ss,
    input  logic       start,
    input  logic       pause,
    output logic [5:0] hh,
    output logic [5:0] mm,
    output logic [5:0] ss,
    output logic       running,
    output logic       done,
    output logic       load_err
);

    localparam logic [5:0] c_MS_MAX = 6'd59;
    localparam logic [5:0] c_HH_MAX = 6'(HH_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [5:0] r_hh, r_mm, r_ss;
    logic [5:0] w_hh_nxt, w_mm_nxt, w_ss_nxt;
    logic       r_done, r_load_err;
    logic       w_done_nxt, w_load_err_nxt;
    logic       w_load_ok, w_count_zero, w_last_tick;

    assign w_load_ok    = (load_ss <= c_MS_MAX) && (load_mm <= c_MS_MAX) && (load_hh <= c_HH_MAX);
    assign w_count_zero = (r_hh == 6'd0) && (r_mm == 6'd0) && (r_ss == 6'd0);
    assign w_last_tick  = (r_hh == 6'd0) && (r_mm == 6'd0) && (r_ss == 6'd1);

`ifdef AUTO_RELOAD_EN
    logic [5:0] r_rl_hh, r_rl_mm, r_rl_ss;
    logic       w_rl_zero;

    assign w_rl_zero = (r_rl_hh == 6'd0) && (r_rl_mm == 6'd0) && (r_rl_ss == 6'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rl_hh <= 6'd0;
            r_rl_mm <= 6'd0;
            r_rl_ss <= 6'd0;
        end else if (load && w_load_ok) begin
            r_rl_hh <= load_hh;
            r_rl_mm <= load_mm;
            r_rl_ss <= load_ss;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hh       <= 6'd0;
            r_mm       <= 6'd0;
            r_ss       <= 6'd0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hh       <= w_hh_nxt;
            r_mm       <= w_mm_nxt;
            r_ss       <= w_ss_nxt;
            r_done     <= w_done_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    // Request priority: load, then pause, then start; an asserted pause masks start.
    always_comb begin
        w_state_nxt    = r_state;
        w_hh_nxt       = r_hh;
        w_mm_nxt       = r_mm;
        w_ss_nxt       = r_ss;
        w_done_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;
        if (load) begin
            if (w_load_ok) begin
                w_state_nxt = S_IDLE;
                w_hh_nxt    = load_hh;
                w_mm_nxt    = load_mm;
                w_ss_nxt    = load_ss;
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else if (pause) begin
            if (r_state == S_RUN) begin
                w_state_nxt = S_PAUSED;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_count_zero) begin
                            w_state_nxt = S_EXPIRED;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_RUN;
                        end
                    end
                end
                S_PAUSED: begin
                    if (start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (en) begin
                        if (w_last_tick) begin
                            w_done_nxt = 1'b1;
                            w_ss_nxt   = 6'd0;
`ifdef AUTO_RELOAD_EN
                            if (!w_rl_zero) begin
                                w_hh_nxt = r_rl_hh;
                                w_mm_nxt = r_rl_mm;
                                w_ss_nxt = r_rl_ss;
                            end else begin
                                w_state_nxt = S_EXPIRED;
                            end
`else
                            w_state_nxt = S_EXPIRED;
`endif
                        end else if (r_ss != 6'd0) begin
                            w_ss_nxt = r_ss - 6'd1;
                        end else if (r_mm != 6'd0) begin
                            w_ss_nxt = c_MS_MAX;
                            w_mm_nxt = r_mm - 6'd1;
                        end else begin
                            w_ss_nxt = c_MS_MAX;
                            w_mm_nxt = c_MS_MAX;
                            w_hh_nxt = r_hh - 6'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign hh       = r_hh;
    assign mm       = r_mm;
    assign ss       = r_ss;
    assign running  = (r_state == S_RUN);
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_countdown_timer                                                      |
// | Randomized + directed scoreboard bench against a seconds-based model.  |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_countdown_timer;

    localparam int HH_MAX = 23;
`ifdef AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

    logic       clk, reset, en, load, start, pause;
    logic [5:0] load_hh, load_mm, load_ss;
    logic [5:0] hh, mm, ss;
    logic       running, done, load_err;

    countdown_timer #(.HH_MAX(HH_MAX)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
        .start(start), .pause(pause),
        .hh(hh), .mm(mm), .ss(ss),
        .running(running), .done(done), .load_err(load_err)
    );

    typedef struct packed {
        logic [5:0] hh, mm, ss;
        logic       running, done, load_err;
    } obs_t;

    obs_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: remaining time as a plain count of seconds.
    int m_t = 0, m_rl = 0, m_mode = M_IDLE;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t model_obs(input bit d, input bit e);
        obs_t o;
        o.hh       = 6'(m_t / 3600);
        o.mm       = 6'((m_t % 3600) / 60);
        o.ss       = 6'(m_t % 60);
        o.running  = (m_mode == M_RUN);
        o.done     = d;
        o.load_err = e;
        return o;
    endfunction

    task automatic report(input string name, input obs_t g, input obs_t x);
        n_vec++;
        if (g !== x) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got %0d:%0d:%0d run=%b done=%b err=%b, expected %0d:%0d:%0d run=%b done=%b err=%b",
                     name, cyc, g.hh, g.mm, g.ss, g.running, g.done, g.load_err,
                     x.hh, x.mm, x.ss, x.running, x.done, x.load_err);
        end
    endtask

    function automatic obs_t dut_obs();
        obs_t o;
        o = {hh, mm, ss, running, done, load_err};
        return o;
    endfunction

    // Drive one edge's worth of requests and push what the model predicts after it.
    task automatic step(input bit ld, input int lh, input int lm, input int ls,
                        input bit st, input bit pa, input bit e);
        bit d, er;
        load = ld; load_hh = 6'(lh); load_mm = 6'(lm); load_ss = 6'(ls);
        start = st; pause = pa; en = e;
        d = 1'b0; er = 1'b0;
        if (ld) begin
            if (ls <= 59 && lm <= 59 && lh <= HH_MAX) begin
                m_t = lh * 3600 + lm * 60 + ls;
                m_rl = m_t;
                m_mode = M_IDLE;
            end else begin
                er = 1'b1;
            end
        end else if (pa) begin
            if (m_mode == M_RUN) m_mode = M_PAUSED;
        end else if (st && m_mode == M_IDLE) begin
            if (m_t == 0) begin m_mode = M_EXP; d = 1'b1; end
            else m_mode = M_RUN;
        end else if (st && m_mode == M_PAUSED) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN && e) begin
            m_t = m_t - 1;
            if (m_t == 0) begin
                d = 1'b1;
                if (AUTO && m_rl != 0) m_t = m_rl;
                else m_mode = M_EXP;
            end
        end
        q.push_back(model_obs(d, er));
        @(negedge clk);
    endtask

    task automatic idle_step(input bit st, input bit pa, input bit e);
        step(1'b0, 0, 0, 0, st, pa, e);
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        m_t = 0; m_rl = 0; m_mode = M_IDLE;
        report("async_reset", dut_obs(), model_obs(1'b0, 1'b0));
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every rising edge presents a new registered observation.
    initial begin
        obs_t x;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                x = q.pop_front();
                report("cycle", dut_obs(), x);
            end
        end
    end

    initial begin
        int r;
        reset = 1'b1; en = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        load_hh = 6'd0; load_mm = 6'd0; load_ss = 6'd0;
        #7;
        report("reset_state", dut_obs(), model_obs(1'b0, 1'b0));
        @(negedge clk);
        reset = 1'b0;

        // 3-second countdown to expiry, then start/pause ignored in EXPIRED
        step(1, 0, 0, 3, 0, 0, 0);
        idle_step(1, 0, 1);
        repeat (4) idle_step(0, 0, 1);
        idle_step(1, 0, 1);
        idle_step(0, 1, 1);

        // hour borrow
        step(1, 1, 0, 0, 0, 0, 0);
        idle_step(1, 0, 0);
        idle_step(0, 0, 1);
        idle_step(0, 0, 1);
        idle_step(0, 0, 0);

        // invalid loads leave state alone; HH_MAX boundary accepted
        step(1, 0, 0, 60, 0, 0, 1);
        step(1, 24, 0, 0, 0, 0, 1);
        step(1, 0, 60, 0, 0, 0, 1);
        step(1, 23, 59, 59, 1, 1, 1);
        idle_step(1, 0, 1);
        idle_step(0, 0, 1);

        // pause wins over start with en on the same edge; resume later
        step(1, 0, 0, 7, 0, 0, 0);
        idle_step(1, 0, 1);
        idle_step(0, 0, 1);
        idle_step(0, 0, 1);
        idle_step(1, 1, 1);
        idle_step(0, 0, 1);
        idle_step(1, 0, 1);
        idle_step(0, 0, 1);

        // zero load then start
        step(1, 0, 0, 0, 0, 0, 0);
        idle_step(1, 0, 1);
        idle_step(0, 0, 1);
        idle_step(1, 0, 1);

        // reload behaviour (expires normally without the macro)
        step(1, 0, 0, 2, 0, 0, 0);
        idle_step(1, 0, 1);
        repeat (7) idle_step(0, 0, 1);

        // reset in the middle of a run, then a normal first edge
        step(1, 0, 0, 4, 0, 0, 0);
        idle_step(1, 0, 1);
        idle_step(0, 0, 1);
        async_reset();
        idle_step(1, 0, 1);
        idle_step(0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit ld;
            int lh, lm, ls;
            if ($urandom_range(0, 299) == 0) async_reset();
            ld = ($urandom_range(0, 99) < 6);
            r  = $urandom_range(0, 9);
            if (r < 6) begin
                lh = 0; lm = $urandom_range(0, 1); ls = $urandom_range(0, 5);
            end else if (r < 8) begin
                lh = $urandom_range(0, HH_MAX); lm = $urandom_range(0, 59); ls = $urandom_range(0, 59);
            end else begin
                lh = $urandom_range(0, 63); lm = $urandom_range(0, 63); ls = $urandom_range(0, 63);
            end
            step(ld, lh, lm, ls, ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 70));
        end

        #2;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected observations left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
